dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the four byte-lane dmem banks (synchronous read, 1-cycle latency) between two requesters: the CPU execution stage (port C) and a UART program loader/debug master (port L).
- Port C has fixed priority. A starvation guard forces one grant to port L after STARVE_LIMIT consecutive denied cycles; the CPU is stalled for that cycle.
- Sits between cpu_top's dmem address/byte-enable/data logic and the dmem_0..dmem_3 instances. Read data is routed back to the requester that issued the read.

Parameters:
- ADDR_W, 32, width of request and memory addresses (already rebased, i.e. base 0x10000 removed).
- STARVE_LIMIT, 4, consecutive denied cycles of port L before a forced grant; legal range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- c_req  in  1  CPU access request (load or store)
- c_we  in  4  CPU byte write enables; 0000 means read
- c_addr  in  ADDR_W  CPU address
- c_wdata  in  32  CPU lane-aligned write data
- c_gnt  out  1  CPU request accepted this cycle
- c_stall  out  1  c_req high and not granted; CPU must hold its instruction
- c_rvalid  out  1  CPU read data valid
- c_rdata  out  32  CPU read data
- l_req  in  1  loader request
- l_we  in  4  loader byte write enables; 0000 means read
- l_addr  in  ADDR_W  loader address
- l_wdata  in  32  loader write data
- l_gnt  out  1  loader request accepted this cycle
- l_rvalid  out  1  loader read data valid
- l_rdata  out  32  loader read data
- mem_we  out  4  per-bank write enables to dmem_0..3
- mem_addr  out  ADDR_W  address to all banks
- mem_wdata  out  32  {bank3,bank2,bank1,bank0} write bytes
- mem_rdata  in  32  {bank3..bank0} read bytes, valid 1 cycle after address

Behaviour:
- Reset (rst_n low, asynchronous):
  - starve_cnt = 0; rd_owner = NONE.
  - c_rvalid = l_rvalid = 0; c_rdata = l_rdata = 0.
  - Grant outputs are 0 while in reset.
- Grant is combinational from the requests and the registered starve_cnt:
  - force_l = l_req && (starve_cnt == STARVE_LIMIT).
  - l_gnt = l_req && (!c_req || force_l).
  - c_gnt = c_req && !force_l.
  - c_gnt and l_gnt are never high together.
  - c_stall = c_req && !c_gnt.
- Memory mux (combinational):
  - The granted port drives mem_addr, mem_we and mem_wdata.
  - With no grant: mem_we = 0000, mem_addr = 0, mem_wdata = 0.
  - A non-granted store must never reach mem_we.
- starve_cnt update on clk:
  - Cleared when l_req is low or l_gnt is high.
  - Otherwise increments and saturates at STARVE_LIMIT.
  - Result: when both ports request continuously, L gets exactly 1 grant every STARVE_LIMIT+1 cycles.
- Read return (registered; latency 1):
  - On a granted read (we == 0000), the next cycle asserts the owner's rvalid for exactly one cycle.
  - The owner's rdata = mem_rdata during that cycle; the other port's rvalid stays 0.
  - rdata holds its last value when rvalid is 0.
  - A granted write produces no rvalid.
- Back-to-back:
  - Reads from alternating owners are legal on consecutive cycles.
  - Each returns to its own port in order; no bubble is inserted.
- Simultaneous events:
  - C read + L write with force_l: L write executes, C stalls, C is re-presented next cycle.
  - Same-address ordering follows grant order.
- Reset mid-read: any pending rvalid is dropped; the read is not replayed.
- Requesters must hold req, we, addr and wdata stable until gnt is seen.

Test Plan:
- Reset, then c_req=1, c_we=1111, c_addr=0x40, c_wdata=0xDEADBEEF -> c_gnt=1 same cycle; mem_we=1111; next cycle c_req read 0x40 -> c_rvalid one cycle later with c_rdata=0xDEADBEEF, l_rvalid=0.
- l_req only, read 0x40 -> l_gnt=1 immediately; l_rvalid=1 next cycle with l_rdata=0xDEADBEEF; c_rvalid stays 0.
- c_req and l_req held high for 15 cycles, STARVE_LIMIT=4 -> l_gnt at cycles 5, 10, 15 only; c_stall=1 exactly those cycles; c_gnt otherwise; mem_we never shows L bytes outside l_gnt.
- l_req high for 3 cycles, dropped for 1, raised again with c_req held -> starve_cnt restarts; L first granted 5 cycles after the re-raise.
- Byte store c_we=0100, c_wdata=0x00AB0000 at 0x41 -> mem_we=0100 only; a later L read of 0x40 returns bank2 byte 0xAB with other bytes unchanged.
- Granted read followed by rst_n low for 1 cycle mid-flight -> c_rvalid=0 after reset; starve_cnt=0; first post-reset L request with c_req high waits the full 4 cycles.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//
// Bundles every bus signal around the dmem arbiter. There are three groups:
// the CPU execution-stage port (c_*), the UART loader/debug port (l_*) and
// the shared byte-lane memory side (mem_*) that feeds dmem_0..dmem_3.
//
// Modports:
//   slave  - the arbiter: takes requests and read data, returns grants,
//            stall, read-return data and the muxed memory command.
//   master - the surrounding system (CPU, loader and memory banks), which is
//            the mirror image of the slave view.
//
// Signal summary:
//   c_req/l_req      request strobe, held until the matching gnt
//   c_we/l_we        byte write enables, 4'b0000 means read
//   c_addr/l_addr    rebased byte address
//   c_wdata/l_wdata  lane-aligned write data
//   c_gnt/l_gnt      request accepted this cycle
//   c_stall          CPU requested but was not granted
//   c_rvalid/l_rvalid, c_rdata/l_rdata   read return, one cycle after grant
//   mem_we/mem_addr/mem_wdata            command to the four banks
//   mem_rdata        {bank3..bank0} read bytes, one cycle after the address
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    // CPU port
    logic              c_req;
    logic [3:0]        c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_wdata;
    logic              c_gnt;
    logic              c_stall;
    logic              c_rvalid;
    logic [31:0]       c_rdata;

    // Loader port
    logic              l_req;
    logic [3:0]        l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [31:0]       l_wdata;
    logic              l_gnt;
    logic              l_rvalid;
    logic [31:0]       l_rdata;

    // Shared memory banks
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_stall, c_rvalid, c_rdata,
        input  l_req, l_we, l_addr, l_wdata,
        output l_gnt, l_rvalid, l_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_stall, c_rvalid, c_rdata,
        output l_req, l_we, l_addr, l_wdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the four byte-lane dmem banks between the CPU execution stage
// (port C, fixed priority) and the UART program loader (port L). A starvation
// counter gives L one forced grant after STARVE_LIMIT consecutive denied
// cycles; the CPU is stalled for that one cycle. Read data returns one cycle
// after the grant to whichever port issued the read.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    dmem_arbiter_if.slave, carrying the C port, the L port and the
//          shared memory command / read-data bus
//
// Parameters:
//   ADDR_W        width of the (already rebased) byte addresses
//   STARVE_LIMIT  denied cycles of L before a forced grant, 1..255
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);

    // The counter only ever needs to reach STARVE_LIMIT, which fits in 8 bits.
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    // Which port the read data arriving next cycle belongs to.
    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_C    = 2'd1,
        OWNER_L    = 2'd2
    } owner_t;

    owner_t      rd_owner_reg;
    logic [7:0]  starve_cnt_reg;
    logic [31:0] c_rdata_hold_reg;
    logic [31:0] l_rdata_hold_reg;

    logic        force_l;
    logic        c_gnt;
    logic        l_gnt;
    logic        c_read;
    logic        l_read;
    logic        c_rvalid;
    logic        l_rvalid;

    // -------------------------------------------------------------------------
    // Grant logic
    // -------------------------------------------------------------------------
    // force_l steals exactly one cycle from the CPU once L has waited long
    // enough. Grants are qualified with rst_n so nothing reaches the banks
    // while the block is held in reset.
    assign force_l = bus.l_req && (starve_cnt_reg == STARVE_MAX);
    assign l_gnt   = rst_n && bus.l_req && (!bus.c_req || force_l);
    assign c_gnt   = rst_n && bus.c_req && !force_l;

    assign bus.c_gnt   = c_gnt;
    assign bus.l_gnt   = l_gnt;
    assign bus.c_stall = bus.c_req && !c_gnt;

    assign c_read = c_gnt && (bus.c_we == 4'b0000);
    assign l_read = l_gnt && (bus.l_we == 4'b0000);

    // -------------------------------------------------------------------------
    // Memory command mux
    // -------------------------------------------------------------------------
    // Byte enables and write lanes are built per lane so a store from the
    // losing port can never leak into mem_we; with no grant everything is 0.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign bus.mem_we[gi] = (c_gnt && bus.c_we[gi]) ||
                                    (l_gnt && bus.l_we[gi]);

            assign bus.mem_wdata[8*gi +: 8] =
                c_gnt ? bus.c_wdata[8*gi +: 8] :
                l_gnt ? bus.l_wdata[8*gi +: 8] :
                        8'h00;
        end
    endgenerate

    assign bus.mem_addr = c_gnt ? bus.c_addr :
                          l_gnt ? bus.l_addr :
                                  {ADDR_W{1'b0}};

    // -------------------------------------------------------------------------
    // Starvation counter, read owner and read-data hold registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg   <= 8'd0;
            rd_owner_reg     <= OWNER_NONE;
            c_rdata_hold_reg <= 32'd0;
            l_rdata_hold_reg <= 32'd0;
        end else begin
            // Count consecutive cycles in which L asked and was refused.
            if (!bus.l_req || l_gnt) begin
                starve_cnt_reg <= 8'd0;
            end else if (starve_cnt_reg != STARVE_MAX) begin
                starve_cnt_reg <= starve_cnt_reg + 8'd1;
            end

            // At most one grant per cycle, so at most one read is in flight.
            if (c_read) begin
                rd_owner_reg <= OWNER_C;
            end else if (l_read) begin
                rd_owner_reg <= OWNER_L;
            end else begin
                rd_owner_reg <= OWNER_NONE;
            end

            // Capture the returned word so rdata keeps it after rvalid drops.
            if (rd_owner_reg == OWNER_C) begin
                c_rdata_hold_reg <= bus.mem_rdata;
            end
            if (rd_owner_reg == OWNER_L) begin
                l_rdata_hold_reg <= bus.mem_rdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read return
    // -------------------------------------------------------------------------
    // The banks present data one cycle after the address, which is exactly
    // the cycle rd_owner_reg names the owner, so the bank output is passed
    // straight through during rvalid and the held copy is shown otherwise.
    assign c_rvalid = (rd_owner_reg == OWNER_C);
    assign l_rvalid = (rd_owner_reg == OWNER_L);

    assign bus.c_rvalid = c_rvalid;
    assign bus.l_rvalid = l_rvalid;
    assign bus.c_rdata  = c_rvalid ? bus.mem_rdata : c_rdata_hold_reg;
    assign bus.l_rdata  = l_rvalid ? bus.mem_rdata : l_rdata_hold_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Drives the arbiter through directed scenarios and a randomized phase.
// A byte-lane bank model sits on the memory side; a reference model tracks
// the expected memory image, the expected grant decision and the expected
// read returns, and every cycle's outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    // Reference model state
    int          l_wait;       // cycles L has been asking without a grant
    int          pend_owner;   // 0 none, 1 CPU, 2 loader: read due next cycle
    logic [31:0] pend_data;
    logic [31:0] c_hold;
    logic [31:0] l_hold;
    logic [31:0] ref_mem [64];

    dmem_arbiter_if #(.ADDR_W(32)) bus ();

    dmem_arbiter #(
        .ADDR_W      (32),
        .STARVE_LIMIT(LIMIT)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Four byte-wide banks with a registered read, addressed by word.
    logic [7:0] bank [4][64];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.mem_we[b]) bank[b][bus.mem_addr[7:2]] <= bus.mem_wdata[8*b +: 8];
        end
        bus.mem_rdata <= {bank[3][bus.mem_addr[7:2]], bank[2][bus.mem_addr[7:2]],
                          bank[1][bus.mem_addr[7:2]], bank[0][bus.mem_addr[7:2]]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One bus cycle: called at posedge+1, drives both ports, checks at the
    // falling edge, then advances the reference model across the next edge.
    task automatic step(input logic cr, input logic [3:0] cw, input logic [31:0] ca,
                        input logic [31:0] cd, input logic lr, input logic [3:0] lw,
                        input logic [31:0] la, input logic [31:0] ld,
                        output logic cg, output logic lg);
        logic        forced;
        logic [3:0]  e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        int          w;
        bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
        bus.l_req = lr; bus.l_we = lw; bus.l_addr = la; bus.l_wdata = ld;
        #4;
        forced  = lr && (l_wait == LIMIT);
        lg      = lr && (!cr || forced);
        cg      = cr && !forced;
        e_we    = cg ? cw : (lg ? lw : 4'b0000);
        e_addr  = cg ? ca : (lg ? la : 32'd0);
        e_wdata = cg ? cd : (lg ? ld : 32'd0);
        check("c_gnt", 32'(bus.c_gnt), 32'(cg));
        check("l_gnt", 32'(bus.l_gnt), 32'(lg));
        check("c_stall", 32'(bus.c_stall), 32'(cr && !cg));
        check("mem_we", 32'(bus.mem_we), 32'(e_we));
        check("mem_addr", bus.mem_addr, e_addr);
        check("mem_wdata", bus.mem_wdata, e_wdata);
        check("c_rvalid", 32'(bus.c_rvalid), 32'(pend_owner == 1));
        check("l_rvalid", 32'(bus.l_rvalid), 32'(pend_owner == 2));
        check("c_rdata", bus.c_rdata, (pend_owner == 1) ? pend_data : c_hold);
        check("l_rdata", bus.l_rdata, (pend_owner == 2) ? pend_data : l_hold);
        if (pend_owner == 1) c_hold = pend_data;
        if (pend_owner == 2) l_hold = pend_data;
        @(posedge clk);
        #1;
        pend_owner = 0;
        if (cg || lg) begin
            w = int'(e_addr[7:2]);
            if (e_we == 4'b0000) begin
                pend_owner = cg ? 1 : 2;
                pend_data  = ref_mem[w];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (e_we[b]) ref_mem[w][8*b +: 8] = e_wdata[8*b +: 8];
                end
            end
        end
        if (!lr || lg) l_wait = 0;
        else if (l_wait < LIMIT) l_wait++;
    endtask

    initial begin
        logic        cg;
        logic        lg;
        int          idx;
        logic        c_act;
        logic        l_act;
        logic [3:0]  r_cwe;
        logic [3:0]  r_lwe;
        logic [31:0] r_caddr;
        logic [31:0] r_laddr;
        logic [31:0] r_cdata;
        logic [31:0] r_ldata;

        vectors = 0; miscompares = 0;
        l_wait = 0; pend_owner = 0; pend_data = 0; c_hold = 0; l_hold = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;

        // Reset with both requests asserted: nothing may be granted.
        rst_n = 1'b0;
        bus.c_req = 1'b1; bus.c_we = 4'hF; bus.c_addr = 32'h10; bus.c_wdata = 32'h1111_2222;
        bus.l_req = 1'b1; bus.l_we = 4'hF; bus.l_addr = 32'h14; bus.l_wdata = 32'h3333_4444;
        repeat (2) @(posedge clk);
        #4;
        check("rst_c_gnt", 32'(bus.c_gnt), 32'd0);
        check("rst_l_gnt", 32'(bus.l_gnt), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_c_rvalid", 32'(bus.c_rvalid), 32'd0);
        check("rst_l_rvalid", 32'(bus.l_rvalid), 32'd0);
        check("rst_c_rdata", bus.c_rdata, 32'd0);
        check("rst_l_rdata", bus.l_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill all 64 words through the loader so the image is fully known.
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 4'hF, 32'(i * 4), $urandom, cg, lg);
        end

        // CPU full-word store then read-back.
        step(1'b1, 4'hF, 32'h40, 32'hDEAD_BEEF, 1'b0, 4'h0, 32'd0, 32'd0, cg, lg);
        check("t1_store_gnt", 32'(cg), 32'd1);
        step(1'b1, 4'h0, 32'h40, 32'd0, 1'b0, 4'h0, 32'd0, 32'd0, cg, lg);
        check("t1_c_rvalid", 32'(bus.c_rvalid), 32'd1);
        check("t1_c_rdata", bus.c_rdata, 32'hDEAD_BEEF);
        check("t1_l_rvalid", 32'(bus.l_rvalid), 32'd0);

        // Loader-only read of the same word.
        step(1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 4'h0, 32'h40, 32'd0, cg, lg);
        check("t2_l_gnt", 32'(lg), 32'd1);
        check("t2_l_rvalid", 32'(bus.l_rvalid), 32'd1);
        check("t2_l_rdata", bus.l_rdata, 32'hDEAD_BEEF);
        check("t2_c_rvalid", 32'(bus.c_rvalid), 32'd0);

        // Both held for 15 cycles: L wins on cycles 5, 10 and 15 only.
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 4'h0, 32'h40, 32'd0, 1'b1, 4'hF, 32'h80, 32'h1234_5678, cg, lg);
            check("starve_pattern", 32'(lg), 32'((i % 5) == 4));
        end

        // L asks 3 cycles, drops 1, then re-asks: first grant on the 5th cycle.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'h0, 32'h40, 32'd0, 1'b1, 4'h0, 32'h80, 32'd0, cg, lg);
        end
        step(1'b1, 4'h0, 32'h40, 32'd0, 1'b0, 4'h0, 32'd0, 32'd0, cg, lg);
        idx = -1;
        for (int i = 0; i < 10 && idx < 0; i++) begin
            step(1'b1, 4'h0, 32'h40, 32'd0, 1'b1, 4'h0, 32'h80, 32'd0, cg, lg);
            if (lg) idx = i;
        end
        check("rearm_latency", 32'(idx), 32'd4);

        // Single-byte store into lane 2, then a loader read of the word.
        step(1'b1, 4'b0100, 32'h41, 32'h00AB_0000, 1'b0, 4'h0, 32'd0, 32'd0, cg, lg);
        step(1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 4'h0, 32'h40, 32'd0, cg, lg);
        check("t5_l_rvalid", 32'(bus.l_rvalid), 32'd1);
        check("t5_l_rdata", bus.l_rdata, 32'hDEAB_BEEF);

        // Reset while a CPU read is returning: the return is dropped.
        step(1'b1, 4'h0, 32'h40, 32'd0, 1'b0, 4'h0, 32'd0, 32'd0, cg, lg);
        rst_n = 1'b0;
        #1;
        check("midrst_c_rvalid", 32'(bus.c_rvalid), 32'd0);
        check("midrst_c_rdata", bus.c_rdata, 32'd0);
        check("midrst_c_gnt", 32'(bus.c_gnt), 32'd0);
        pend_owner = 0; c_hold = 0; l_hold = 0; l_wait = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idx = -1;
        for (int i = 0; i < 10 && idx < 0; i++) begin
            step(1'b1, 4'h0, 32'h40, 32'd0, 1'b1, 4'h0, 32'h44, 32'd0, cg, lg);
            if (lg) idx = i;
        end
        check("post_rst_latency", 32'(idx), 32'd4);

        // Randomized traffic; each port holds its request until granted.
        c_act = 1'b0; l_act = 1'b0;
        r_cwe = 4'h0; r_lwe = 4'h0; r_caddr = 32'd0; r_laddr = 32'd0;
        r_cdata = 32'd0; r_ldata = 32'd0;
        for (int n = 0; n < 400; n++) begin
            if (!c_act && ($urandom_range(0, 99) < 60)) begin
                c_act   = 1'b1;
                r_cwe   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                r_caddr = 32'($urandom_range(0, 255));
                r_cdata = $urandom;
            end
            if (!l_act && ($urandom_range(0, 99) < 50)) begin
                l_act   = 1'b1;
                r_lwe   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                r_laddr = 32'($urandom_range(0, 255));
                r_ldata = $urandom;
            end
            step(c_act, r_cwe, r_caddr, r_cdata, l_act, r_lwe, r_laddr, r_ldata, cg, lg);
            if (cg) c_act = 1'b0;
            if (lg) l_act = 1'b0;
        end

        // Drain the last read return.
        repeat (2) step(1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 4'h0, 32'd0, 32'd0, cg, lg);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
